gps_fxp_mul_arbiter: RTL
========================

Name: gps_fxp_mul_arbiter

Overview:
Shares one pipelined signed Q8.8 multiplier among NUM_REQ requesters (tracking-channel correlator/NCO/loop-filter stages). Round-robin arbitration accepts at most one operand pair per cycle. Each result returns after a fixed latency, tagged to its requester. Arithmetic uses the project Q8.8 format (16 bits total, 8 fractional bits).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MUL_LAT, 2, cycles from accept edge to result valid (1..4)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; kills in-flight ops and blocks grant this cycle
req_valid  in  NUM_REQ  per-requester operand valid
req_a  in  16*NUM_REQ  operand A, Q8.8 signed, requester i at [16*i+:16]
req_b  in  16*NUM_REQ  operand B, Q8.8 signed, same packing
req_ready  out  NUM_REQ  one-hot grant; accept = req_valid[i] & req_ready[i] at clk rise
rsp_valid  out  NUM_REQ  one-hot result strobe, one cycle
rsp_data  out  16  Q8.8 result, broadcast to all requesters
rsp_sat  out  1  result saturated, qualified by any rsp_valid
busy  out  1  any op in flight

Behaviour:
- Reset (async assert, sync deassert assumed upstream): rsp_valid=0, rsp_data=0, rsp_sat=0, busy=0, RR pointer=0, pipeline valid bits cleared.
- req_ready is combinational from req_valid, pointer and flush. It is never asserted to a requester with req_valid=0. It is all-zero when flush=1.
- Arbitration: scan from pointer upward, wrapping modulo NUM_REQ. Grant the first valid requester. After a grant to i, pointer becomes (i+1) mod NUM_REQ. With no grant, pointer holds.
- Requesters hold valid/a/b stable until accepted. Deasserting valid without acceptance is allowed.
- Pipeline: the stage-0 register captures a, b and a one-hot tag on accept. Results are registered through MUL_LAT stages. The op accepted at edge t drives rsp_valid[tag]=1, rsp_data and rsp_sat during the cycle after edge t+MUL_LAT-1, i.e. exactly MUL_LAT cycles later. Throughput is 1 op/cycle. There is no response backpressure.
- Arithmetic: p = a*b as signed 32 bits. r = (p + 0x80) >>> 8, arithmetic shift (round half toward +inf). If r > 32767, output 0x7FFF and set sat=1. If r < -32768, output 0x8000 and set sat=1. Otherwise output r[15:0] and set sat=0.
- rsp_data holds its last value when rsp_valid is all zero. rsp_sat is 0 when no rsp_valid.
- flush=1: all pipeline valid bits clear on that edge. No rsp_valid is produced for killed ops. No accept occurs that cycle. Pointer holds.
- busy = OR of pipeline valid bits.
- Reset mid-operation: all in-flight ops are dropped silently. No rsp_valid follows reset release.
- Single-requester continuous valid: accepted every cycle, results back-to-back.

Optional Feature:
GPS_MUL_SAT_CNT_EN
- Defined: adds input sat_cnt_clr (1) and output sat_cnt (16).
- sat_cnt increments on every result with rsp_sat=1 and sticks at 0xFFFF.
- sat_cnt_clr=1 clears it to 0; clear wins over a simultaneous increment.
- sat_cnt resets to 0.
- Undefined: the ports and counter are absent; all other behaviour is identical.

Test Plan:
- Basic: req0 a=0x0180, b=0x0200 (1.5×2.0) -> rsp_valid[0] exactly MUL_LAT cycles after accept, rsp_data=0x0300, rsp_sat=0.
- Sign/rounding: a=0xFF00, b=0x0324 -> 0xFCDC. a=0x0001, b=0x0080 -> 0x0001. a=0xFFFF, b=0x0080 -> 0x0000.
- Saturation: a=0x7F00, b=0x0200 -> 0x7FFF with sat=1. a=0x8000, b=0x0200 -> 0x8000 with sat=1. Under GPS_MUL_SAT_CNT_EN, sat_cnt=2; then assert sat_cnt_clr with a coincident sat result -> sat_cnt=0.
- Fairness: all 4 valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Each result tag matches its requester and returns in order.
- Flush: accept ops on 3 consecutive cycles, assert flush for 1 cycle -> no rsp_valid for the killed ops, no accept that cycle, busy=0 next cycle, pointer unchanged.
- Reset mid-flight: assert rst_n=0 with 2 ops in flight -> outputs go to 0 immediately. After release, no rsp_valid and the first grant goes to requester 0.

Source files
------------

// File: rtl/gps_fxp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined signed Q8.8 multiplier.
// Optional saturation counter: define GPS_MUL_SAT_CNT_EN.
module gps_fxp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [15:0]          rsp_data,
    output logic                 rsp_sat,
    output logic                 busy
`ifdef GPS_MUL_SAT_CNT_EN
    ,
    input  logic                 sat_cnt_clr,
    output logic [15:0]          sat_cnt
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RS = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gidx;
    logic [NUM_REQ-1:0] gnt;
    logic               acc;
    logic [15:0]        ga;
    logic [15:0]        gb;
    logic [15:0]        ma;
    logic [15:0]        mb;
    logic               mv;
    logic [16:0]        mres;
    logic [MUL_LAT-1:0] pv;
    logic [NUM_REQ-1:0] ptag [MUL_LAT];
    logic [15:0]        rd [RS];
    logic               rs [RS];

    function automatic logic [16:0] fxmul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        logic signed [31:0] r;
        p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
        r = (p + 32'sd128) >>> 8;
        if (r > 32'sd32767)
            fxmul = {1'b1, 16'h7FFF};
        else if (r < -32'sd32768)
            fxmul = {1'b1, 16'h8000};
        else
            fxmul = {1'b0, r[15:0]};
    endfunction

    // Two passes: requesters at/above the pointer first, then wrap.
    always_comb begin
        gnt  = '0;
        gidx = ptr;
        acc  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!acc && PW'(i) >= ptr && req_valid[i]) begin
                acc    = 1'b1;
                gnt[i] = 1'b1;
                gidx   = PW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!acc && req_valid[i]) begin
                acc    = 1'b1;
                gnt[i] = 1'b1;
                gidx   = PW'(i);
            end
        end
        if (flush) begin
            gnt = '0;
            acc = 1'b0;
        end
    end

    always_comb begin
        ga = '0;
        gb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                ga = req_a[16*i +: 16];
                gb = req_b[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (acc)
            ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end

    generate
        if (MUL_LAT == 1) begin : g_direct
            assign ma = ga;
            assign mb = gb;
            assign mv = acc;
        end else begin : g_s0
            logic [15:0] s0a;
            logic [15:0] s0b;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s0a <= '0;
                    s0b <= '0;
                end else if (acc) begin
                    s0a <= ga;
                    s0b <= gb;
                end
            end
            assign ma = s0a;
            assign mb = s0b;
            assign mv = pv[0] & ~flush;
        end
    endgenerate

    assign mres = fxmul(ma, mb);

    // Result stages only advance with a live op, so rsp_data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RS; k++) begin
                rd[k] <= '0;
                rs[k] <= 1'b0;
            end
        end else begin
            if (mv) begin
                rd[0] <= mres[15:0];
                rs[0] <= mres[16];
            end
            for (int k = 1; k < RS; k++) begin
                if (pv[k] && !flush) begin
                    rd[k] <= rd[k-1];
                    rs[k] <= rs[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int k = 0; k < MUL_LAT; k++)
                ptag[k] <= '0;
        end else begin
            pv[0]   <= acc;
            ptag[0] <= gnt;
            for (int k = 1; k < MUL_LAT; k++) begin
                pv[k]   <= pv[k-1] & ~flush;
                ptag[k] <= ptag[k-1];
            end
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = pv[MUL_LAT-1] ? ptag[MUL_LAT-1] : '0;
    assign rsp_data  = rd[RS-1];
    assign rsp_sat   = pv[MUL_LAT-1] & rs[RS-1];
    assign busy      = |pv;

`ifdef GPS_MUL_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt <= '0;
        else if (sat_cnt_clr)
            sat_cnt <= '0;
        else if (rsp_sat && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
    end
`endif

endmodule
